// File: rtl/ahb_master_resp_sel_pkg.sv
// ---------------------------------------------------------------------------
// ahb_master_resp_sel_pkg
//   Shared AHB definitions for the master-side decoder / response select.
//   - htrans_t        : AHB transfer types
//   - HRESP_OKAY/ERROR: HRESP encodings
//   - def_slv_state_t : default-slave FSM states (IDLE, ERR1, ERR2)
//   - SLV_*_DEF       : default three-slave address map (256 MB regions)
//   - is_active_xfer  : true for NONSEQ/SEQ, the transfers that need a response
// ---------------------------------------------------------------------------
package ahb_master_resp_sel_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_t;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } def_slv_state_t;

  localparam int SLV_NUM_DEF    = 3;
  localparam int ADDR_WIDTH_DEF = 32;

  localparam logic [SLV_NUM_DEF-1:0][ADDR_WIDTH_DEF-1:0] SLV_BASE_DEF =
    {32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
  localparam logic [SLV_NUM_DEF-1:0][ADDR_WIDTH_DEF-1:0] SLV_MASK_DEF =
    {3{32'hF000_0000}};

  function automatic logic is_active_xfer(input logic [1:0] trans);
    return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_master_resp_sel_default_slave.sv
// ---------------------------------------------------------------------------
// ahb_default_slave
//   Default slave that answers unmapped NONSEQ/SEQ transfers with the AHB
//   two-cycle ERROR response, and counts the errors it issues.
//   Ports:
//     clk_i, rst_i  clock, asynchronous active-high reset
//     hready_i      bus HREADY; transfers are only sampled when high
//     err_req_i     address phase is an unmapped NONSEQ/SEQ transfer
//     state_o       current FSM state (drives HREADYOUT/HRESP upstream)
//     err_cnt_o     saturating count of ERROR responses (entries to ERR1)
// ---------------------------------------------------------------------------
module ahb_default_slave
  import ahb_master_resp_sel_pkg::*;
(
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           hready_i,
  input  logic           err_req_i,
  output def_slv_state_t state_o,
  output logic [7:0]     err_cnt_o
);

  def_slv_state_t state_q, state_d;
  logic [7:0]     err_cnt_q, err_cnt_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      DS_IDLE: if (hready_i && err_req_i) state_d = DS_ERR1;
      // First error cycle holds HREADYOUT low, so nothing is sampled here.
      DS_ERR1: state_d = DS_ERR2;
      // Second error cycle has HREADYOUT high: a new unmapped transfer
      // chains straight into another error without an OKAY gap.
      DS_ERR2: state_d = (hready_i && err_req_i) ? DS_ERR1 : DS_IDLE;
      default: state_d = DS_IDLE;
    endcase
  end

  // ERR1 never follows itself, so state_d == ERR1 marks an entry.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if ((state_d == DS_ERR1) && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= DS_IDLE;
      err_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign state_o   = state_q;
  assign err_cnt_o = err_cnt_q;

endmodule

// File: rtl/ahb_master_resp_sel.sv
// ---------------------------------------------------------------------------
// ahb_master_resp_sel
//   Master-side address decoder plus data-phase select register feeding the
//   response mux. Unmapped NONSEQ/SEQ transfers are answered by a default
//   slave; while it owns the data phase resp_sel_o is zero so the mux drives
//   '0 and the default-slave response is merged downstream.
//   Build option: define AHB_DEF_SLAVE_EN to include the default slave.
//   Without it, unmapped transfers complete as zero-wait OKAY.
//   Ports:
//     HCLK, HRESET   clock, asynchronous active-high reset
//     haddr, htrans  master address phase
//     hready_in      merged bus HREADY
//     hsel_o         combinational one-hot slave select (address phase)
//     resp_sel_o     registered one-hot select for the response mux
//     def_hreadyout  default-slave HREADYOUT
//     def_hresp      default-slave HRESP (0 OKAY, 1 ERROR)
//     def_active     default slave owns the current data phase
//     err_cnt        saturating count of ERROR responses
// ---------------------------------------------------------------------------
module ahb_master_resp_sel
  import ahb_master_resp_sel_pkg::*;
#(
  parameter int SLV_NUM    = SLV_NUM_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter logic [SLV_NUM-1:0][ADDR_WIDTH-1:0] SLV_BASE = SLV_BASE_DEF,
  parameter logic [SLV_NUM-1:0][ADDR_WIDTH-1:0] SLV_MASK = SLV_MASK_DEF
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]            htrans,
  input  logic                  hready_in,
  output logic [SLV_NUM-1:0]    hsel_o,
  output logic [SLV_NUM-1:0]    resp_sel_o,
  output logic                  def_hreadyout,
  output logic                  def_hresp,
  output logic                  def_active,
  output logic [7:0]            err_cnt
);

  logic [SLV_NUM-1:0] hsel_c;
  logic [SLV_NUM-1:0] resp_sel_q;

  // Walk from the highest index down so the lowest matching index is the
  // one left standing; the result is one-hot or zero even with overlaps.
  always_comb begin
    hsel_c = '0;
    for (int i = SLV_NUM - 1; i >= 0; i--) begin
      if ((haddr & SLV_MASK[i]) == SLV_BASE[i]) begin
        hsel_c    = '0;
        hsel_c[i] = 1'b1;
      end
    end
  end

  assign hsel_o = hsel_c;

  // Wait states stretch the data phase, so the select only advances with
  // hready_in.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      resp_sel_q <= '0;
    end else if (hready_in) begin
      resp_sel_q <= hsel_c;
    end
  end

  assign resp_sel_o = resp_sel_q;

`ifdef AHB_DEF_SLAVE_EN
  logic           err_req;
  logic           def_active_q;
  def_slv_state_t def_state;

  assign err_req = (hsel_c == '0) && is_active_xfer(htrans);

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      def_active_q <= 1'b0;
    end else if (hready_in) begin
      def_active_q <= err_req;
    end
  end

  ahb_default_slave u_def_slave (
    .clk_i     (HCLK),
    .rst_i     (HRESET),
    .hready_i  (hready_in),
    .err_req_i (err_req),
    .state_o   (def_state),
    .err_cnt_o (err_cnt)
  );

  assign def_active    = def_active_q;
  assign def_hreadyout = (def_state != DS_ERR1);
  assign def_hresp     = (def_state == DS_IDLE) ? HRESP_OKAY : HRESP_ERROR;
`else
  // htrans only qualifies default-slave errors; without it nothing reads it.
  logic unused_htrans;
  assign unused_htrans = ^htrans;

  assign def_active    = 1'b0;
  assign def_hreadyout = 1'b1;
  assign def_hresp     = HRESP_OKAY;
  assign err_cnt       = 8'd0;
`endif

endmodule

// File: tb/tb_ahb_master_resp_sel.sv
module tb_ahb_master_resp_sel;

`ifdef AHB_DEF_SLAVE_EN
  localparam bit DEF_EN = 1'b1;
`else
  localparam bit DEF_EN = 1'b0;
`endif

  localparam logic [1:0] T_IDLE   = 2'd0;
  localparam logic [1:0] T_BUSY   = 2'd1;
  localparam logic [1:0] T_NONSEQ = 2'd2;
  localparam logic [1:0] T_SEQ    = 2'd3;

  logic        HCLK;
  logic        HRESET;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hready_in;
  logic [2:0]  hsel_o;
  logic [2:0]  resp_sel_o;
  logic        def_hreadyout;
  logic        def_hresp;
  logic        def_active;
  logic [7:0]  err_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: expected data-phase select stream, default-slave
  // ownership, position inside an error response (0 none, 1 first, 2 second)
  // and number of errors issued so far.
  logic [2:0] exp_q[$];
  bit         m_def_active;
  int         m_phase;
  int         m_err_cnt;

  ahb_master_resp_sel dut (
    .HCLK          (HCLK),
    .HRESET        (HRESET),
    .haddr         (haddr),
    .htrans        (htrans),
    .hready_in     (hready_in),
    .hsel_o        (hsel_o),
    .resp_sel_o    (resp_sel_o),
    .def_hreadyout (def_hreadyout),
    .def_hresp     (def_hresp),
    .def_active    (def_active),
    .err_cnt       (err_cnt)
  );

  // ---------------- clock / reset ----------------
  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // ---------------- model ----------------
  // Default map: 256 MB regions 0,1,2 belong to slaves 0,1,2.
  function automatic logic [2:0] model_decode(input logic [31:0] a);
    int region;
    region = int'(a[31:28]);
    return (region < 3) ? 3'(1 << region) : 3'b000;
  endfunction

  function automatic logic [13:0] model_vec();
    logic hr, hp;
    hr = (m_phase != 1);
    hp = (m_phase != 0);
    return {exp_q[0], m_def_active, hr, hp, 8'(m_err_cnt)};
  endfunction

  task automatic model_reset();
    exp_q.delete();
    exp_q.push_back(3'b000);
    m_def_active = 1'b0;
    m_phase      = 0;
    m_err_cnt    = 0;
  endtask

  task automatic model_update();
    logic [2:0] hs;
    bit unm, act, start;
    hs    = model_decode(haddr);
    unm   = (hs == 3'b000);
    act   = (htrans == T_NONSEQ) || (htrans == T_SEQ);
    start = DEF_EN && hready_in && unm && act;
    if (hready_in) begin
      exp_q.push_back(hs);
      if (exp_q.size() > 1) exp_q.delete(0);
      m_def_active = DEF_EN && unm && act;
    end
    if (m_phase == 1) begin
      m_phase = 2;
    end else if (start) begin
      m_phase = 1;
      if (m_err_cnt < 255) m_err_cnt++;
    end else begin
      m_phase = 0;
    end
  endtask

  function automatic bit bus_ready();
    return (m_phase != 1);
  endfunction

  function automatic logic [31:0] rand_unmapped();
    return {4'($urandom_range(3, 15)), 28'($urandom)};
  endfunction

  // ---------------- drivers ----------------
  task automatic apply(input logic [31:0] a, input logic [1:0] t, input logic r);
    haddr     = a;
    htrans    = t;
    hready_in = r;
    #1;
  endtask

  task automatic tick();
    @(posedge HCLK);
    model_update();
    @(negedge HCLK);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [13:0] obs;
    HRESET = 1'b1;
    model_reset();
    apply(32'h0, T_IDLE, 1'b1);
    repeat (2) @(negedge HCLK);
    obs = {resp_sel_o, def_active, def_hreadyout, def_hresp, err_cnt};
    checks++;
    if (obs !== 14'b000_0_1_0_00000000) begin
      errors++;
      $display("FAIL reset_state got=%b want=%b", obs, 14'b000_0_1_0_00000000);
    end
    HRESET = 1'b0;
  endtask

  task automatic test_decode();
    logic [13:0] obs;
    apply(32'h1000_0040, T_NONSEQ, 1'b1);
    checks++;
    if (hsel_o !== 3'b010) begin
      errors++;
      $display("FAIL decode_hsel got=%b want=%b", hsel_o, 3'b010);
    end
    tick();
    checks++;
    if (resp_sel_o !== 3'b010) begin
      errors++;
      $display("FAIL decode_resp_sel got=%b want=%b", resp_sel_o, 3'b010);
    end
    obs = {resp_sel_o, def_active, def_hreadyout, def_hresp, err_cnt};
    checks++;
    if (obs !== model_vec()) begin
      errors++;
      $display("FAIL decode_state got=%b want=%b", obs, model_vec());
    end
  endtask

  task automatic test_error();
    logic [13:0] obs;
    apply(32'h8000_0000, T_NONSEQ, 1'b1);
    checks++;
    if (hsel_o !== 3'b000) begin
      errors++;
      $display("FAIL error_hsel got=%b want=%b", hsel_o, 3'b000);
    end
    tick();
    checks++;
    if ({def_active, def_hreadyout, def_hresp} !== {DEF_EN, !DEF_EN, DEF_EN}) begin
      errors++;
      $display("FAIL error_first_cycle got=%b want=%b",
               {def_active, def_hreadyout, def_hresp}, {DEF_EN, !DEF_EN, DEF_EN});
    end
    for (int c = 0; c < 2; c++) begin
      apply(32'h0000_0100, T_IDLE, bus_ready());
      tick();
      obs = {resp_sel_o, def_active, def_hreadyout, def_hresp, err_cnt};
      checks++;
      if (obs !== model_vec()) begin
        errors++;
        $display("FAIL error_seq%0d got=%b want=%b", c, obs, model_vec());
      end
    end
    checks++;
    if (err_cnt !== (DEF_EN ? 8'd1 : 8'd0)) begin
      errors++;
      $display("FAIL error_count got=%0d want=%0d", err_cnt, DEF_EN ? 1 : 0);
    end
  endtask

  task automatic test_back_to_back();
    logic [13:0] obs;
    logic [31:0] a_tab[5];
    logic [1:0]  t_tab[5];
    a_tab = '{32'h9000_0000, 32'hA000_0000, 32'hA000_0000, 32'h0, 32'h0};
    t_tab = '{T_NONSEQ, T_NONSEQ, T_NONSEQ, T_IDLE, T_IDLE};
    for (int c = 0; c < 5; c++) begin
      apply(a_tab[c], t_tab[c], bus_ready());
      tick();
      obs = {resp_sel_o, def_active, def_hreadyout, def_hresp, err_cnt};
      checks++;
      if (obs !== model_vec()) begin
        errors++;
        $display("FAIL b2b_cycle%0d got=%b want=%b", c, obs, model_vec());
      end
    end
    checks++;
    if (err_cnt !== (DEF_EN ? 8'd3 : 8'd0)) begin
      errors++;
      $display("FAIL b2b_count got=%0d want=%0d", err_cnt, DEF_EN ? 3 : 0);
    end
  endtask

  task automatic test_busy_unmapped();
    logic [13:0] obs;
    apply(32'h8000_0000, T_BUSY, 1'b1);
    tick();
    obs = {resp_sel_o, def_active, def_hreadyout, def_hresp, err_cnt};
    checks++;
    if (obs !== model_vec() || def_hresp !== 1'b0 || def_hreadyout !== 1'b1) begin
      errors++;
      $display("FAIL busy_unmapped got=%b want=%b", obs, model_vec());
    end
  endtask

  task automatic test_wait_states();
    apply(32'h1000_0000, T_NONSEQ, 1'b1);
    tick();
    for (int c = 0; c < 3; c++) begin
      apply(32'h2000_0000, T_NONSEQ, 1'b0);
      tick();
      checks++;
      if (resp_sel_o !== 3'b010) begin
        errors++;
        $display("FAIL wait_hold%0d got=%b want=%b", c, resp_sel_o, 3'b010);
      end
    end
    apply(32'h2000_0000, T_NONSEQ, 1'b1);
    tick();
    checks++;
    if (resp_sel_o !== 3'b100) begin
      errors++;
      $display("FAIL wait_release got=%b want=%b", resp_sel_o, 3'b100);
    end
  endtask

  task automatic test_reset_mid_error();
    logic [13:0] obs;
    apply(32'hF000_0000, T_NONSEQ, 1'b1);
    tick();
    #2;
    HRESET = 1'b1;
    model_reset();
    #1;
    obs = {resp_sel_o, def_active, def_hreadyout, def_hresp, err_cnt};
    checks++;
    if (obs !== 14'b000_0_1_0_00000000) begin
      errors++;
      $display("FAIL async_reset got=%b want=%b", obs, 14'b000_0_1_0_00000000);
    end
    apply(32'h0, T_IDLE, 1'b1);
    @(negedge HCLK);
    HRESET = 1'b0;
  endtask

  task automatic test_saturation();
    logic [13:0] obs;
    int bad = 0;
    for (int c = 0; c < 600; c++) begin
      apply(rand_unmapped(), T_NONSEQ, bus_ready());
      tick();
      obs = {resp_sel_o, def_active, def_hreadyout, def_hresp, err_cnt};
      checks++;
      if (obs !== model_vec()) begin
        errors++;
        if (bad++ < 5) $display("FAIL sat_cycle%0d got=%b want=%b", c, obs, model_vec());
      end
    end
    checks++;
    if (err_cnt !== (DEF_EN ? 8'hFF : 8'h00)) begin
      errors++;
      $display("FAIL sat_final got=%h want=%h", err_cnt, DEF_EN ? 8'hFF : 8'h00);
    end
    apply(32'h0, T_IDLE, bus_ready());
    tick();
    apply(32'h0, T_IDLE, 1'b1);
    tick();
  endtask

  task automatic test_random();
    logic [13:0] obs;
    logic [31:0] a;
    logic [1:0]  t;
    logic        r;
    int bad = 0;
    HRESET = 1'b1;
    model_reset();
    @(negedge HCLK);
    HRESET = 1'b0;
    for (int c = 0; c < 400; c++) begin
      a = {4'($urandom_range(0, 15)), 28'($urandom)};
      t = 2'($urandom_range(0, 3));
      r = bus_ready() ? ($urandom_range(0, 3) != 0) : 1'b0;
      apply(a, t, r);
      checks++;
      if (hsel_o !== model_decode(a)) begin
        errors++;
        if (bad++ < 5) $display("FAIL rand_hsel%0d got=%b want=%b", c, hsel_o, model_decode(a));
      end
      tick();
      obs = {resp_sel_o, def_active, def_hreadyout, def_hresp, err_cnt};
      checks++;
      if (obs !== model_vec()) begin
        errors++;
        if (bad++ < 5) $display("FAIL rand_state%0d got=%b want=%b", c, obs, model_vec());
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    HRESET    = 1'b1;
    haddr     = '0;
    htrans    = T_IDLE;
    hready_in = 1'b1;
    model_reset();
    test_reset();
    test_decode();
    test_error();
    test_back_to_back();
    test_busy_unmapped();
    test_wait_states();
    test_reset_mid_error();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_master_resp_sel.md
Name: ahb_master_resp_sel

Overview:
- Master-side address decoder and data-phase select register; sits directly upstream of the master-side response mux.
- Decodes the master's address-phase HADDR into a one-hot slave select.
- Registers that select into the data phase, where it drives the response mux `sel` input.
- Contains a default slave that gives the AHB two-cycle ERROR response to unmapped NONSEQ/SEQ transfers. When the default slave owns the data phase, `resp_sel` is all-zero, so the mux outputs '0 and the default-slave response is merged downstream.

Parameters:
- SLV_NUM, 3, number of slave channels; equals the response mux channel count.
- ADDR_WIDTH, 32, HADDR width.
- SLV_BASE, {32'h2000_0000, 32'h1000_0000, 32'h0000_0000}, per-slave base address, packed [SLV_NUM-1:0][ADDR_WIDTH-1:0]; index 0 is the rightmost element.
- SLV_MASK, {3{32'hF000_0000}}, per-slave address compare mask, same packing.

Ports:
- HCLK  input  1  system clock.
- HRESET  input  1  asynchronous reset, active-high.
- haddr  input  ADDR_WIDTH  master address-phase address.
- htrans  input  2  master transfer type: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- hready_in  input  1  bus HREADY, fed back from the merged response.
- hsel_o  output  SLV_NUM  address-phase one-hot select to the slaves; combinational.
- resp_sel_o  output  SLV_NUM  data-phase one-hot select to the response mux; registered.
- def_hreadyout  output  1  default-slave HREADYOUT.
- def_hresp  output  1  default-slave HRESP: 0=OKAY, 1=ERROR.
- def_active  output  1  default slave owns the current data phase.
- err_cnt  output  8  saturating count of ERROR responses issued.

Behaviour:
- Decode: match[i] = ((haddr & SLV_MASK[i]) == SLV_BASE[i]).
  - Overlapping matches: the lowest index wins; hsel_o is strictly one-hot or zero.
  - unmapped = (hsel_o == 0).
- hsel_o is purely combinational and independent of htrans; the slaves qualify it with htrans.
- Data-phase register:
  - On a rising HCLK edge with hready_in=1: resp_sel_o <= hsel_o.
  - On the same edge: def_active <= unmapped & htrans[1].
  - With hready_in=0 both hold their values; wait states extend the data phase.
- Default-slave FSM (state encoding in the package): IDLE, ERR1, ERR2.
  - IDLE: def_hreadyout=1, def_hresp=0. Move to ERR1 when hready_in & unmapped & htrans[1]; otherwise stay.
  - ERR1: def_hreadyout=0, def_hresp=1. Always moves to ERR2 on the next edge.
  - ERR2: def_hreadyout=1, def_hresp=1. Move to ERR1 if hready_in & unmapped & htrans[1] (back-to-back error); otherwise IDLE.
- Transfers of type IDLE or BUSY to unmapped addresses get a zero-wait OKAY: the FSM stays in IDLE and def_active stays 0.
- Latency:
  - address phase -> resp_sel_o valid: 1 cycle.
  - unmapped NONSEQ -> first ERROR cycle: 1 cycle.
  - error response length: exactly 2 cycles.
- err_cnt increments by 1 on every entry to ERR1 and saturates at 8'hFF; it does not wrap.
- Reset (asynchronous, immediate, including mid-error):
  - resp_sel_o=0, def_active=0, FSM=IDLE.
  - def_hreadyout=1, def_hresp=0, err_cnt=0.
- A master abort after the ERR1 cycle (htrans=IDLE at ERR2) is legal: the FSM goes to IDLE.
- The FSM ignores htrans while in ERR1; transfers are sampled only when hready_in=1.

Optional Feature:
- Macro AHB_DEF_SLAVE_EN.
- Defined: default-slave FSM, def_active and err_cnt behave as described above.
- Undefined:
  - FSM and counter are not instantiated.
  - def_hreadyout is tied to 1, def_hresp to 0, def_active to 0, err_cnt to 0.
  - Unmapped transfers complete as zero-wait OKAY with resp_sel_o=0.

Decomposition:
- Shared AHB package:
  - htrans_t enum (IDLE/BUSY/NONSEQ/SEQ).
  - HRESP_OKAY and HRESP_ERROR constants.
  - def_slv_state_t enum (IDLE/ERR1/ERR2).
  - Default address-map constants.
- One natural sub-module: ahb_default_slave. It holds the FSM and err_cnt and is instantiated only under AHB_DEF_SLAVE_EN. The top level keeps the decoder and the data-phase register.

Test Plan:
- Reset then NONSEQ to 32'h1000_0040 with hready_in=1 -> hsel_o=3'b010 the same cycle; resp_sel_o=3'b010 the next cycle; def_hreadyout=1, def_hresp=0.
- NONSEQ to 32'h8000_0000 -> hsel_o=0. Next cycle: def_active=1, def_hreadyout=0, def_hresp=1. Following cycle: def_hreadyout=1, def_hresp=1. Then IDLE; err_cnt=1.
- Back-to-back: two unmapped NONSEQs, the second presented during ERR2 -> ERR1, ERR2, ERR1, ERR2 with no OKAY gap; err_cnt=2.
- hready_in=0 held for 3 cycles during a slave-1 data phase while haddr changes to 32'h2000_0000 -> resp_sel_o stays 3'b010 throughout; updates to 3'b100 on the first edge with hready_in=1.
- HRESET pulsed during ERR1 -> asynchronously: def_hreadyout=1, def_hresp=0, resp_sel_o=0, err_cnt=0. Also, 256 error transfers -> err_cnt=8'hFF, with no wrap after further errors.
- Macro undefined, BUSY or NONSEQ to 32'h8000_0000 -> def_hreadyout stays 1, def_hresp stays 0, resp_sel_o=0.
